// File: rtl/uart_axi_probe_pkg.sv
// Shared definitions for the UART-controlled AXI-lite probe: opcodes, FSM
// states and status byte layout.
package uart_axi_probe_pkg;

  localparam logic [3:0] OP_GPI_RD    = 4'h1;
  localparam logic [3:0] OP_GPO_RD    = 4'h2;
  localparam logic [3:0] OP_GPO_WR    = 4'h3;
  localparam logic [3:0] OP_ADDR_RD   = 4'h4;
  localparam logic [3:0] OP_ADDR_WR   = 4'h5;
  localparam logic [3:0] OP_DATA_RD   = 4'h6;
  localparam logic [3:0] OP_DATA_WR   = 4'h7;
  localparam logic [3:0] OP_AXI_READ  = 4'h8;
  localparam logic [3:0] OP_AXI_WRITE = 4'h9;
  localparam logic [3:0] OP_STATUS_RD = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARG, ST_TX, ST_AR, ST_R, ST_AWW, ST_B, ST_RESP
  } state_t;

  localparam int STAT_TIMEOUT_BIT = 2;
  localparam int STAT_WRITE_BIT   = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  function automatic logic [7:0] make_status(input logic [1:0] resp,
                                             input logic timeout,
                                             input logic is_wr);
    logic [7:0] s;
    s                   = 8'h00;
    s[1:0]              = resp;
    s[STAT_TIMEOUT_BIT] = timeout;
    s[STAT_WRITE_BIT]   = is_wr;
    return s;
  endfunction

endpackage

// File: rtl/uart_axi_probe_axi.sv
// AXI-lite master engine: drives the AR/R/AWW/B phases chosen by the top FSM
// and reports completion, response and timeout.
module uart_axi_probe_axi import uart_axi_probe_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        m_areset,
  input  state_t      i_state,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output state_t      o_next_state,
  output logic        o_cpl,
  output logic [1:0]  o_resp,
  output logic        o_timeout,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [2:0]  m_axi_arsize,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [2:0]  m_axi_awsize,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_aw_done;
  logic             r_w_done;
  logic             w_in_axi;
  logic             w_expire;
  logic             w_step;

  assign w_in_axi = i_state inside {ST_AR, ST_R, ST_AWW, ST_B};
  assign w_expire = (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  assign m_axi_araddr  = i_addr;
  assign m_axi_awaddr  = i_addr;
  assign m_axi_wdata   = i_wdata;
  assign m_axi_wstrb   = i_wstrb;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_arvalid = (i_state == ST_AR);
  assign m_axi_rready  = (i_state == ST_R);
  assign m_axi_awvalid = (i_state == ST_AWW) && !r_aw_done;
  assign m_axi_wvalid  = (i_state == ST_AWW) && !r_w_done;
  assign m_axi_bready  = (i_state == ST_B);

  // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
  always_ff @(posedge clk or posedge m_areset) begin
    if (m_areset) begin
      r_cnt     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (i_start) begin
      r_cnt     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_in_axi) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (m_axi_awvalid && m_axi_awready) r_aw_done <= 1'b1;
      if (m_axi_wvalid && m_axi_wready)   r_w_done  <= 1'b1;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    o_next_state = i_state;
    o_cpl        = 1'b0;
    o_resp       = RESP_OKAY;
    o_timeout    = 1'b0;
    w_step       = 1'b0;
    case (i_state)
      ST_AR: begin
        w_step = m_axi_arready;
        if (w_step) o_next_state = ST_R;
      end
      ST_R: begin
        w_step = m_axi_rvalid;
        if (w_step) begin
          o_next_state = ST_RESP;
          o_cpl        = 1'b1;
          o_resp       = m_axi_rresp;
        end
      end
      ST_AWW: begin
        w_step = (r_aw_done || m_axi_awready) && (r_w_done || m_axi_wready);
        if (w_step) o_next_state = ST_B;
      end
      ST_B: begin
        w_step = m_axi_bvalid;
        if (w_step) begin
          o_next_state = ST_RESP;
          o_cpl        = 1'b1;
          o_resp       = m_axi_bresp;
        end
      end
      default: ;
    endcase
    // A handshake landing on the expiry cycle wins over the timeout.
    if (w_in_axi && !w_step && w_expire) begin
      o_next_state = ST_RESP;
      o_cpl        = 1'b1;
      o_timeout    = 1'b1;
    end
  end

endmodule

// File: rtl/uart_axi_probe.sv
// UART byte-command front end: decodes commands, holds GPO/address/data/status
// registers and hands AXI transactions to the engine.
module uart_axi_probe import uart_axi_probe_pkg::*; #(
  parameter int           GPIO_W            = 32,
  parameter logic [127:0] GPO_ON_RESET      = 128'hDEAD_BEEF,
  parameter logic [31:0]  AXI_ADDR_ON_RESET = 32'h0,
  parameter int           TIMEOUT_CYCLES    = 1024,
  parameter bit           AUTO_INC          = 1'b0
) (
  input  logic              clk,
  input  logic              m_areset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [GPIO_W-1:0] gpo,
  input  logic [GPIO_W-1:0] gpi,
  output logic [31:0]       m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [2:0]        m_axi_arsize,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [31:0]       m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [2:0]        m_axi_awsize,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  localparam int                GPIO_BYTES = GPIO_W / 8;
  localparam logic [GPIO_W-1:0] GPO_RST    = GPO_ON_RESET[GPIO_W-1:0];

  state_t            r_state, w_next, w_axi_next;
  logic [GPIO_W-1:0] r_gpo;
  logic [31:0]       r_addr, r_data;
  logic [7:0]        r_status, r_tx_data, w_rd_byte, w_new_status;
  logic [3:0]        r_arg_op, r_arg_idx, r_wstrb;
  logic              r_is_wr;
  logic              w_rx_fire, w_start, w_cpl, w_timeout;
  logic [1:0]        w_resp;
  logic [3:0]        w_op, w_idx;

  assign w_op      = rx_data[7:4];
  assign w_idx     = rx_data[3:0];
  assign rx_ready  = (r_state == ST_IDLE || r_state == ST_ARG) && !m_areset;
  assign w_rx_fire = rx_valid && rx_ready;
  assign w_start   = w_rx_fire && (r_state == ST_IDLE) &&
                     (w_op == OP_AXI_READ || w_op == OP_AXI_WRITE);
  assign tx_valid  = (r_state == ST_TX || r_state == ST_RESP);
  assign tx_data   = r_tx_data;
  assign gpo       = r_gpo;
  assign w_new_status = make_status(w_resp, w_timeout, r_is_wr);

  uart_axi_probe_axi #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_axi (
    .clk(clk), .m_areset(m_areset), .i_state(r_state), .i_start(w_start),
    .i_addr(r_addr), .i_wdata(r_data), .i_wstrb(r_wstrb),
    .o_next_state(w_axi_next), .o_cpl(w_cpl), .o_resp(w_resp), .o_timeout(w_timeout),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arsize(m_axi_arsize), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_awsize(m_axi_awsize), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_op)
      OP_GPI_RD:
        for (int i = 0; i < GPIO_BYTES; i++) if (w_idx == 4'(i)) w_rd_byte = gpi[i*8 +: 8];
      OP_GPO_RD:
        for (int i = 0; i < GPIO_BYTES; i++) if (w_idx == 4'(i)) w_rd_byte = r_gpo[i*8 +: 8];
      OP_ADDR_RD:
        for (int i = 0; i < 4; i++) if (w_idx == 4'(i)) w_rd_byte = r_addr[i*8 +: 8];
      OP_DATA_RD:
        for (int i = 0; i < 4; i++) if (w_idx == 4'(i)) w_rd_byte = r_data[i*8 +: 8];
      OP_STATUS_RD: w_rd_byte = r_status;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (w_rx_fire) begin
          case (w_op)
            OP_GPI_RD, OP_GPO_RD, OP_ADDR_RD, OP_DATA_RD, OP_STATUS_RD: w_next = ST_TX;
            OP_GPO_WR, OP_ADDR_WR, OP_DATA_WR:                          w_next = ST_ARG;
            OP_AXI_READ:  w_next = ST_AR;
            OP_AXI_WRITE: w_next = ST_AWW;
            default:      w_next = ST_IDLE;
          endcase
        end
      ST_ARG:           if (w_rx_fire) w_next = ST_IDLE;
      ST_TX, ST_RESP:   if (tx_ready)  w_next = ST_IDLE;
      default:          w_next = w_axi_next;
    endcase
  end

  always_ff @(posedge clk or posedge m_areset) begin
    if (m_areset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or posedge m_areset) begin
    if (m_areset) begin
      r_gpo     <= GPO_RST;
      r_addr    <= AXI_ADDR_ON_RESET;
      r_data    <= '0;
      r_status  <= '0;
      r_tx_data <= '0;
      r_arg_op  <= '0;
      r_arg_idx <= '0;
      r_wstrb   <= '0;
      r_is_wr   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_rx_fire) begin
        r_tx_data <= w_rd_byte;
        r_arg_op  <= w_op;
        r_arg_idx <= w_idx;
        r_is_wr   <= (w_op == OP_AXI_WRITE);
        if (w_op == OP_AXI_WRITE) r_wstrb <= w_idx;
      end
      // Out-of-range indices match no byte lane, so the argument is dropped.
      if (r_state == ST_ARG && w_rx_fire) begin
        case (r_arg_op)
          OP_GPO_WR:
            for (int i = 0; i < GPIO_BYTES; i++) if (r_arg_idx == 4'(i)) r_gpo[i*8 +: 8] <= rx_data;
          OP_ADDR_WR:
            for (int i = 0; i < 4; i++) if (r_arg_idx == 4'(i)) r_addr[i*8 +: 8] <= rx_data;
          OP_DATA_WR:
            for (int i = 0; i < 4; i++) if (r_arg_idx == 4'(i)) r_data[i*8 +: 8] <= rx_data;
          default: ;
        endcase
      end
      if (w_cpl) begin
        r_status  <= w_new_status;
        r_tx_data <= w_new_status;
        if (!r_is_wr && !w_timeout) r_data <= m_axi_rdata;
        if (AUTO_INC && !w_timeout && w_resp == RESP_OKAY) r_addr <= r_addr + 32'd4;
      end
    end
  end

endmodule

// File: doc/uart_axi_probe.md
UART_AXI_PROBE -- requirements
Module: uart_axi_probe

Interface
REQ-001 Parameter GPIO_W, default 32, GPIO width in bits; multiple of 8, range 8..128.
REQ-002 Parameter GPO_ON_RESET, default 32'hDEAD_BEEF, zero-extended/truncated to GPIO_W; gpo reset value.
REQ-003 Parameter AXI_ADDR_ON_RESET, default 32'h0, address register reset value.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, cycles allowed per AXI transaction (>=2).
REQ-005 Parameter AUTO_INC, default 0, when 1 address += 4 after each OKAY AXI transaction.
REQ-006 One clock; reset is asynchronous and active-high: clk in 1 clock; m_areset in 1 async active-high reset.
REQ-007 rx_valid in 1, rx_data in 8, rx_ready out 1: UART receive byte stream.
REQ-008 tx_valid out 1, tx_data out 8, tx_ready in 1: UART transmit byte stream.
REQ-009 gpo out GPIO_W registered outputs; gpi in GPIO_W inputs.
REQ-010 AXI-lite master, 32-bit: m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready, m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready; arsize/awsize out 3 fixed 3'b010.

Function
REQ-011 Command byte: cmd[7:4] opcode, cmd[3:0] index/strobe; byte accepted when rx_valid && rx_ready.
REQ-012 Opcodes: 1 GPI_RD, 2 GPO_RD, 3 GPO_WR, 4 ADDR_RD, 5 ADDR_WR, 6 DATA_RD, 7 DATA_WR, 8 AXI_READ, 9 AXI_WRITE, A STATUS_RD; others consumed and ignored, FSM stays IDLE.
REQ-013 States: IDLE, ARG, TX, AR, R, AWW, B, RESP.
REQ-014 rx_ready = 1 only in IDLE and ARG and only while m_areset low; no byte is accepted in any other state.
REQ-015 Read opcodes (1,2,4,6,A): selected byte registered into tx_data on accept cycle N; tx_valid high from N+1 until tx_ready seen; then IDLE.
REQ-016 Byte index beyond register width (GPIO_W/8 for GPIO, 4 for ADDR/DATA) returns 8'h00.
REQ-017 GPI byte sampled on the command accept cycle.
REQ-018 Write opcodes (3,5,7): IDLE -> ARG; next accepted byte written to indexed byte, other bytes unchanged; -> IDLE; out-of-range index consumes byte and discards it.
REQ-019 AXI_READ: IDLE -> AR, arvalid=1 until arready; -> R, rready=1 until rvalid; data register <= rdata, status updated; -> RESP.
REQ-020 AXI_WRITE: wstrb = cmd[3:0]; awvalid and wvalid asserted together in AWW, each dropped independently on own handshake (either order, or same cycle); both done -> B, bready=1 until bvalid -> RESP.
REQ-021 wdata = data register; araddr = awaddr = address register.
REQ-022 Timeout counter cleared on AXI command accept, increments each cycle in AR/R/AWW/B; reaching TIMEOUT_CYCLES drops all AXI valids/readies, sets status timeout, -> RESP.
REQ-023 RESP: tx_data = status byte, tx_valid until tx_ready, then IDLE.
REQ-024 Status byte: [1:0] last resp, [2] timeout, [3] last op was write, [7:4] 0; overwritten by every AXI transaction.
REQ-025 AUTO_INC=1: address += 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000) on OKAY resp, not on timeout or error.
REQ-026 Handshake on same cycle as timeout expiry counts as completion, not timeout.

Reset
REQ-027 m_areset asserted: FSM IDLE, gpo=GPO_ON_RESET, address=AXI_ADDR_ON_RESET, data=0, status=0, timeout counter=0.
REQ-028 During reset all AXI valid/ready outputs 0, tx_valid 0, tx_data 0, rx_ready 0.
REQ-029 Reset mid-transaction aborts immediately; no completion, status stays 0.

Structure
REQ-030 Package uart_axi_probe_pkg holds opcode constants, FSM state enum, status bit positions.
REQ-031 AXI engine (AR/R/AWW/B, timeout) is one sub-module uart_axi_probe_axi; top holds command decode, registers, UART side.

Verification
REQ-032 GPO_WR idx 2, data 8'h5A -> gpo = 32'hDE5A_BEEF; GPO_RD idx 2 -> tx byte 8'h5A.
REQ-033 ADDR_WR 0..3 = 10,20,30,40; AXI_READ, slave rdata 32'h1234_5678 OKAY after 3 cycles -> araddr 32'h4030_2010, status 8'h00; DATA_RD idx 0 -> 8'h78.
REQ-034 DATA_WR = 32'hCAFE_F00D, cmd 8'h93, awready 5 cycles before wready -> wstrb 4'h3, wdata CAFE_F00D, status 8'h08.
REQ-035 AXI_READ, slave silent, TIMEOUT_CYCLES=16 -> arvalid drops after 16 cycles, status 8'h04.
REQ-036 AUTO_INC=1, addr FFFF_FFFC, AXI_WRITE OKAY -> addr 0; SLVERR write -> addr unchanged, status 8'h0A.
REQ-037 GPIO_W=64, GPI_RD idx 7 -> gpi[63:56]; idx 9 -> 8'h00; reset asserted in state B -> bready 0, FSM IDLE.
